// File: rtl/ov_reg_init_seq.sv
// Power-up register sequencer for the OV camera: walks a fixed {subaddr,data}
// table and issues one SCCB write per entry through the ov_sccb master.
module ov_reg_init_seq #(
  parameter logic [7:0] CHIP_ADDR    = 8'h42,
  parameter int         PWRUP_CYCLES = 100000,
  parameter int         GAP_CYCLES   = 16,
  parameter int         DELAY_UNIT   = 100000,
  parameter int         TIMEOUT      = 200000,
  parameter int         ROM_DEPTH    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sccb_busy,
  input  logic       sccb_tr_end,
  output logic [7:0] sccb_addr,
  output logic [7:0] sccb_subaddr,
  output logic [7:0] sccb_w_data,
  output logic       sccb_tr_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] index
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_ISSUE, S_WBUSY,
    S_WEND, S_GAP, S_DLY, S_DONE, S_ERROR
  } state_t;

  localparam logic [23:0] PWRUP_LAST = 24'((PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0);
  localparam logic [23:0] GAP_LAST   = 24'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [23:0] TO_LAST    = 24'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [5:0]  IDX_LAST   = 6'(ROM_DEPTH - 1);

  state_t      state;
  logic [23:0] cnt;
  logic [23:0] dly_last;
  logic        busy_q;
  logic        past_end;

  function automatic logic [15:0] rom(input logic [5:0] i);
    case (i)
      6'd0:    rom = 16'h1280;
      6'd1:    rom = 16'hF001;
      6'd2:    rom = 16'h1204;
      6'd3:    rom = 16'h1101;
      6'd4:    rom = 16'h40D0;
      default: rom = 16'hFFFF;
    endcase
  endfunction

  logic [15:0] ent;
  logic [7:0]  ent_sub, ent_dat;
  logic        at_last;
  logic [5:0]  idx_inc;

  assign ent     = rom(index);
  assign ent_sub = ent[15:8];
  assign ent_dat = ent[7:0];
  assign at_last = (index == IDX_LAST);
  // index saturates; past_end marks that the final slot has been consumed
  assign idx_inc = at_last ? index : index + 6'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      dly_last      <= '0;
      busy_q        <= 1'b0;
      past_end      <= 1'b0;
      sccb_addr     <= '0;
      sccb_subaddr  <= '0;
      sccb_w_data   <= '0;
      sccb_tr_start <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      index         <= '0;
    end else begin
      busy_q        <= sccb_busy;
      sccb_tr_start <= 1'b0;
      cnt           <= cnt + 24'd1;
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (start) begin
          state    <= S_PWRUP;
          cnt      <= '0;
          index    <= '0;
          past_end <= 1'b0;
          busy     <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
        end
        S_PWRUP: if (cnt >= PWRUP_LAST) state <= S_FETCH;
        S_FETCH: begin
          if (ent_sub == 8'hFF || past_end) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (ent_sub == 8'hF0) begin
            if (ent_dat == 8'h00) begin
              index    <= idx_inc;
              past_end <= at_last;
            end else begin
              state    <= S_DLY;
              cnt      <= '0;
              dly_last <= 24'(ent_dat) * 24'(DELAY_UNIT) - 24'd1;
            end
          end else begin
            state         <= S_ISSUE;
            sccb_addr     <= CHIP_ADDR;
            sccb_subaddr  <= ent_sub;
            sccb_w_data   <= ent_dat;
            sccb_tr_start <= 1'b1;
          end
        end
        // the ISSUE cycle counts as the first cycle of the busy-rise wait
        S_ISSUE: begin
          state <= S_WBUSY;
          cnt   <= 24'd1;
        end
        S_WBUSY: begin
          if (sccb_busy) begin
            state <= sccb_tr_end ? S_GAP : S_WEND;
            cnt   <= '0;
          end else if (cnt >= TO_LAST) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_WEND: begin
          if (sccb_tr_end || (busy_q && !sccb_busy)) begin
            state <= S_GAP;
            cnt   <= '0;
          end else if (cnt >= TO_LAST) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_GAP: if (cnt >= GAP_LAST) begin
          state    <= S_FETCH;
          index    <= idx_inc;
          past_end <= at_last;
        end
        S_DLY: if (cnt >= dly_last) begin
          state    <= S_FETCH;
          index    <= idx_inc;
          past_end <= at_last;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov_reg_init_seq.sv
// Randomized scoreboard bench for ov_reg_init_seq with a behavioural SCCB responder.
module tb_ov_reg_init_seq;
  localparam int P = 50, G = 4, DU = 100, TO = 2000;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       sccb_busy = 1'b0, sccb_tr_end = 1'b0;
  logic [7:0] sccb_addr, sccb_subaddr, sccb_w_data;
  logic       sccb_tr_start, busy, done, error;
  logic [5:0] index;

  ov_reg_init_seq #(
    .CHIP_ADDR(8'h42), .PWRUP_CYCLES(P), .GAP_CYCLES(G),
    .DELAY_UNIT(DU), .TIMEOUT(TO), .ROM_DEPTH(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .sccb_busy(sccb_busy), .sccb_tr_end(sccb_tr_end),
    .sccb_addr(sccb_addr), .sccb_subaddr(sccb_subaddr), .sccb_w_data(sccb_w_data),
    .sccb_tr_start(sccb_tr_start), .busy(busy), .done(done), .error(error),
    .index(index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sub;
    logic [7:0] dat;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tbl_sub [0:5] = '{8'h12, 8'hF0, 8'h12, 8'h11, 8'h40, 8'hFF};
  logic [7:0] tbl_dat [0:5] = '{8'h80, 8'h01, 8'h04, 8'h01, 8'hD0, 8'hFF};
  int total = 0, bad = 0;
  int cyc = 0, anchor = 0, n_trs = 0, last_trs = 0;
  int exp_idx = 0, exp_n = 0;
  int force_mode = -1;
  bit rsp_silent = 1'b0;
  bit r_active = 1'b0;
  int r_mode = 0, r_rise = 0, r_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected writes from the table: the first write lands PWRUP+FETCH+ISSUE after
  // start, later ones GAP+FETCH+ISSUE after completion; each delay entry adds a
  // FETCH cycle plus data*DELAY_UNIT.
  function automatic void model_push(input bit first_only);
    int lat = P + 2;
    exp_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (tbl_sub[i] == 8'hFF) begin
        exp_idx = i;
        break;
      end
      if (tbl_sub[i] == 8'hF0) lat += 1 + int'(tbl_dat[i]) * DU;
      else begin
        exp_q.push_back('{tbl_sub[i], tbl_dat[i], lat});
        exp_n++;
        lat = G + 2;
        if (first_only) break;
      end
    end
  endfunction

  // Monitor/scoreboard and SCCB responder; inputs change on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      r_active    = 1'b0;
      sccb_busy   = 1'b0;
      sccb_tr_end = 1'b0;
    end else begin
      if (start && !busy) anchor = cyc;
      if (sccb_tr_start) begin
        n_trs++;
        last_trs = cyc;
        if (exp_q.size() == 0) chk("unexpected_tr_start", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sccb_addr", sccb_addr, 8'h42);
          chk("sccb_subaddr", sccb_subaddr, e.sub);
          chk("sccb_w_data", sccb_w_data, e.dat);
          chk("tr_start_latency", cyc - anchor, e.lat);
        end
        if (!rsp_silent) begin
          r_mode   = (force_mode >= 0) ? force_mode : int'($urandom_range(0, 3));
          r_rise   = cyc + int'($urandom_range(1, 3));
          r_fall   = (r_mode == 3) ? r_rise : r_rise + int'($urandom_range(1, 6));
          r_active = 1'b1;
        end
      end
      if (r_active) begin
        case (r_mode)
          0: begin
            sccb_busy   = (cyc >= r_rise && cyc < r_fall);
            sccb_tr_end = (cyc == r_fall);
          end
          1: begin
            sccb_busy   = (cyc >= r_rise && cyc < r_fall);
            sccb_tr_end = 1'b0;
          end
          2: begin
            sccb_busy   = (cyc >= r_rise && cyc <= r_fall);
            sccb_tr_end = (cyc == r_fall);
          end
          default: begin
            sccb_busy   = (cyc == r_rise);
            sccb_tr_end = (cyc == r_rise);
          end
        endcase
        if (cyc == r_fall) anchor = cyc;
        if (cyc >= r_fall + 1) r_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_seq(input bit spurious);
    int n0 = n_trs;
    model_push(1'b0);
    pulse_start();
    chk("accept_flags", {done, error, busy, index}, {1'b0, 1'b0, 1'b1, 6'd0});
    if (spurious) begin
      repeat (10) tick();
      pulse_start();
      for (int i = 0; i < 300 && n_trs == n0; i++) tick();
      repeat (40) tick();
      pulse_start();
    end
    for (int i = 0; i < 3000 && !done; i++) tick();
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("error_at_done", error, 0);
    chk("index_at_done", index, exp_idx);
    chk("write_count", n_trs - n0, exp_n);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n0, err_cyc;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {sccb_addr, sccb_subaddr, sccb_w_data, sccb_tr_start,
                          busy, done, error, index}, 0);
    reset = 1'b1;
    repeat (2) tick();

    // nominal run with ignored starts in PWRUP and DLY, then reruns from DONE
    run_seq(1'b1);
    run_seq(1'b0);
    run_seq(1'b0);

    // reset while the third write is waiting for its end
    force_mode = 0;
    n0 = n_trs;
    model_push(1'b0);
    pulse_start();
    for (int i = 0; i < 1000 && n_trs < n0 + 3; i++) tick();
    for (int i = 0; i < 20 && !sccb_busy; i++) tick();
    chk("reached_entry3_wend", {n_trs - n0, sccb_busy}, {32'd3, 1'b1});
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("midrun_reset_outputs", {sccb_addr, sccb_subaddr, sccb_w_data, sccb_tr_start,
                                 busy, done, error, index}, 0);
    force_mode = -1;
    repeat (5) tick();
    reset = 1'b1;
    repeat (30) tick();
    chk("idle_after_reset", {n_trs - n0, busy, done, error, index}, {32'd3, 9'd0});
    run_seq(1'b0);

    // responder never answers: error exactly TIMEOUT cycles after tr_start
    rsp_silent = 1'b1;
    n0 = n_trs;
    model_push(1'b1);
    pulse_start();
    err_cyc = -1;
    for (int i = 0; i < P + TO + 200 && err_cyc < 0; i++) begin
      tick();
      if (error) err_cyc = cyc;
    end
    chk("timeout_latency", err_cyc - last_trs, TO);
    chk("timeout_flags", {error, busy, done, index}, {1'b1, 1'b0, 1'b0, 6'd0});
    repeat (50) tick();
    chk("no_tr_start_after_error", n_trs - n0, 1);
    chk("timeout_scoreboard_empty", exp_q.size(), 0);
    rsp_silent = 1'b0;

    // restart from ERROR
    run_seq(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
